// File: rtl/mlp_ctrl_pkg.sv
// Shared types and default sizing for the MLP control blocks.
// The layer controller also uses these constants.
package mlp_ctrl_pkg;

    localparam int unsigned DEF_N_INPUTS = 8;
    localparam int unsigned DEF_ADDR_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_BIAS  = 3'd2,
        ST_ACC   = 3'd3,
        ST_DONE  = 3'd4
    } mac_seq_state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// Handshake and MAC-control bundle between the layer controller, the sequencer and one MAC.
// The master modport is the sequencer side; the slave modport is the layer controller / MAC side.
interface mac_sequencer_if
    import mlp_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

    logic              start;
    logic              stall;
    logic              busy;
    logic              done;
    logic              clk_en;
    logic              ctrl_rst;
    logic              use_bias;
    logic [ADDR_W-1:0] addr;

    modport master (
        input  start,
        input  stall,
        output busy,
        output done,
        output clk_en,
        output ctrl_rst,
        output use_bias,
        output addr
    );

    modport slave (
        output start,
        output stall,
        input  busy,
        input  done,
        input  clk_en,
        input  ctrl_rst,
        input  use_bias,
        input  addr
    );

endinterface

// File: rtl/mac_index_counter.sv
// Operand index for the MAC sequence: counts up on enable, saturates at N_INPUTS-1.
// Clear has priority over enable.
module mac_index_counter #(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned N_INPUTS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              enable_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_INPUTS - 1);

    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;
    logic              last;

    assign last = (count_q == LAST_IDX);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !last) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = last;

endmodule

// File: rtl/mac_sequencer.sv
// Sequencing FSM for one MAC neuron: clear, load bias, accumulate N_INPUTS pairs, pulse done.
// Outputs are decoded from state and index; clk_en additionally gates on stall.
//
//   state | meaning
//   IDLE  | waiting for start, accumulator untouched
//   CLEAR | ctrl_rst pulse, accumulator to zero
//   BIAS  | load bias into accumulator (stallable)
//   ACC   | accumulate data[addr]*weight[addr] (stallable)
//   DONE  | one-cycle done, sum_result valid
module mac_sequencer
    import mlp_ctrl_pkg::*;
#(
    parameter int unsigned N_INPUTS = DEF_N_INPUTS,
    parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    mac_sequencer_if.master  bus
);

    mac_seq_state_t    state_q;
    mac_seq_state_t    state_d;

    logic              idx_clear;
    logic              idx_en;
    logic [ADDR_W-1:0] idx_count;
    logic              idx_last;

    logic              busy_c;
    logic              done_c;
    logic              clk_en_c;
    logic              ctrl_rst_c;
    logic              use_bias_c;
    logic [ADDR_W-1:0] addr_c;

    mac_index_counter #(
        .ADDR_W   (ADDR_W),
        .N_INPUTS (N_INPUTS)
    ) u_index (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (idx_clear),
        .enable_i (idx_en),
        .count_o  (idx_count),
        .last_o   (idx_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_clear  = 1'b0;
        idx_en     = 1'b0;
        busy_c     = (state_q != ST_IDLE);
        done_c     = 1'b0;
        clk_en_c   = 1'b0;
        ctrl_rst_c = 1'b0;
        use_bias_c = 1'b0;
        addr_c     = '0;

        case (state_q)
            ST_IDLE: begin
                idx_clear = 1'b1;
                if (bus.start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                ctrl_rst_c = 1'b1;
                state_d    = ST_BIAS;
            end
            ST_BIAS: begin
                use_bias_c = 1'b1;
                clk_en_c   = !bus.stall;
                if (!bus.stall) begin
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                addr_c   = idx_count;
                clk_en_c = !bus.stall;
                if (!bus.stall) begin
                    if (idx_last) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_en = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done_c    = 1'b1;
                idx_clear = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.clk_en   = clk_en_c;
    assign bus.ctrl_rst = ctrl_rst_c;
    assign bus.use_bias = use_bias_c;
    assign bus.addr     = addr_c;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer with a behavioural MAC and a progress-position model.
module tb_mac_sequencer;

    localparam int N  = 4;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_sequencer_if #(.ADDR_W(AW)) bus ();

    mac_sequencer #(
        .N_INPUTS (N),
        .ADDR_W   (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int data   [N] = '{1, 2, 3, 4};
    int weight [N] = '{5, 6, 7, 8};
    int bias       = 10;
    int acc        = 0;

    // Behavioural MAC driven by the sequencer outputs.
    always @(posedge clk) begin
        if (rst || bus.ctrl_rst)
            acc <= 0;
        else if (bus.clk_en)
            acc <= bus.use_bias ? bias : acc + data[bus.addr] * weight[bus.addr];
    end

    int checks     = 0;
    int failures   = 0;
    int done_count = 0;
    int cyc        = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic int expected_sum();
        int s;
        s = bias;
        for (int k = 0; k < N; k++) s += data[k] * weight[k];
        return s;
    endfunction

    // Progress position: 0 idle, 1 clear, 2 bias, 3..N+2 operand k=pos-3, N+3 done.
    int pos = 0;
    always @(posedge clk) begin
        if (rst)
            pos <= 0;
        else if (pos == 0)
            pos <= bus.start ? 1 : 0;
        else if (pos >= 2 && pos <= N + 2 && bus.stall)
            pos <= pos;
        else if (pos == N + 3)
            pos <= 0;
        else
            pos <= pos + 1;
    end

    always @(negedge clk) begin
        int exp_addr;
        exp_addr = (pos >= 3 && pos <= N + 2) ? pos - 3 : 0;
        check("busy",     int'(bus.busy),     int'(pos != 0));
        check("done",     int'(bus.done),     int'(pos == N + 3));
        check("ctrl_rst", int'(bus.ctrl_rst), int'(pos == 1));
        check("use_bias", int'(bus.use_bias), int'(pos == 2));
        check("addr",     int'(bus.addr),     exp_addr);
        check("clk_en",   int'(bus.clk_en),   int'(pos >= 2 && pos <= N + 2 && !bus.stall));
        if (pos == N + 3) check("sum_at_done", acc, expected_sum());
        if (bus.done) done_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_done(input int max_cycles, output int at_cyc);
        bit found;
        found  = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < max_cycles && !found; i++) begin
            tick();
            if (bus.done) begin
                found  = 1'b1;
                at_cyc = cyc;
            end
        end
        check("done_timeout", int'(found), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d1, d2, dn;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        tick();
        tick();
        check("reset_busy", int'(bus.busy), 0);
        check("reset_addr", int'(bus.addr), 0);
        rst = 1'b0;
        tick();

        // Single run, no stall
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1 check("t1_clear_c1", int'(bus.ctrl_rst), 1);
        tick();
        #1 check("t1_bias_c2", int'(bus.use_bias), 1);
        for (int k = 0; k < N; k++) begin
            tick();
            #1 check("t1_addr", int'(bus.addr), k);
            check("t1_clk_en", int'(bus.clk_en), 1);
        end
        tick();
        #1 check("t1_done_c7", int'(bus.done), 1);
        check("t1_sum", acc, 80);
        tick();

        // Stall in BIAS and at addr 2
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.stall = 1'b1;
        #1 check("t2_bias_stall_clk_en", int'(bus.clk_en), 0);
        check("t2_bias_stall_use_bias", int'(bus.use_bias), 1);
        tick();
        bus.stall = 1'b0;
        #1 check("t2_bias_c3", int'(bus.use_bias), 1);
        tick();
        #1 check("t2_addr_c4", int'(bus.addr), 0);
        tick();
        #1 check("t2_addr_c5", int'(bus.addr), 1);
        tick();
        bus.stall = 1'b1;
        #1 check("t2_addr_c6", int'(bus.addr), 2);
        check("t2_stall_clk_en_c6", int'(bus.clk_en), 0);
        tick();
        bus.stall = 1'b0;
        #1 check("t2_addr_c7", int'(bus.addr), 2);
        check("t2_clk_en_c7", int'(bus.clk_en), 1);
        tick();
        #1 check("t2_addr_c8", int'(bus.addr), 3);
        tick();
        #1 check("t2_done_c9", int'(bus.done), 1);
        check("t2_sum", acc, 80);
        tick();

        // Start held high: back-to-back runs
        bus.start = 1'b1;
        t0 = cyc;
        wait_done(20, d1);
        check("t3_first_latency", d1 - t0, 7);
        check("t3_sum1", acc, 80);
        wait_done(20, d2);
        check("t3_spacing", d2 - d1, 8);
        check("t3_sum2", acc, 80);
        bus.start = 1'b0;
        tick();
        tick();

        // Reset mid-ACC
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        #1 check("t4_addr_before_rst", int'(bus.addr), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 check("t4_busy", int'(bus.busy), 0);
        check("t4_done", int'(bus.done), 0);
        check("t4_clk_en", int'(bus.clk_en), 0);
        check("t4_ctrl_rst", int'(bus.ctrl_rst), 0);
        check("t4_use_bias", int'(bus.use_bias), 0);
        check("t4_addr", int'(bus.addr), 0);
        dn = done_count;
        repeat (10) tick();
        check("t4_no_done", done_count, dn);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(15, d1);
        check("t4_sum", acc, 80);

        // Idle hold with stall toggling
        for (int i = 0; i < 20; i++) begin
            tick();
            bus.stall = i[0];
            #1 check("t5_sum_hold", acc, 80);
            check("t5_clk_en", int'(bus.clk_en), 0);
            check("t5_ctrl_rst", int'(bus.ctrl_rst), 0);
            check("t5_busy", int'(bus.busy), 0);
        end
        bus.stall = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
